bbox_tracker: RTL and testbench

- Sits directly downstream of the per-channel binarisation stage in the VGA pipeline.
- Consumes the binarised pixel stream (0x00/0xFF) plus VGA timing.
- Computes the bounding box of white pixels for each frame and reports it at end of frame.
- Overlays the previous frame's box onto the outgoing video in a fixed colour; all outputs are registered, one-cycle latency.

---
 rtl/bbox_tracker.sv | 201 ++++++++++++++++++++
 tb/tb_bbox_tracker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bbox_tracker.sv
// Purpose: bounding box of white pixels per frame, reported at frame end, previous box overlaid on video.
// Latency: every video output is registered, exactly one cycle after its input.
// Backpressure: none; the pixel stream cannot stall, so one pixel is accepted on every clock.
module bbox_tracker #(
  parameter int         X_W     = 10,
  parameter int         Y_W     = 10,
  parameter int         MIN_PIX = 16,
  parameter int         CNT_W   = 20,
  parameter logic [7:0] BOX_R   = 8'hFF,
  parameter logic [7:0] BOX_G   = 8'h00,
  parameter logic [7:0] BOX_B   = 8'h00
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_h_sync,
  input  logic           i_v_sync,
  input  logic           i_vga_blank,
  input  logic [7:0]     i_bin,
  output logic           o_h_sync,
  output logic           o_v_sync,
  output logic           o_vga_blank,
  output logic [7:0]     o_r,
  output logic [7:0]     o_g,
  output logic [7:0]     o_b,
  output logic           o_box_valid,
  output logic           o_box_found,
  output logic [X_W-1:0] o_x_min,
  output logic [X_W-1:0] o_x_max,
  output logic [Y_W-1:0] o_y_min,
  output logic [Y_W-1:0] o_y_max
);

  typedef enum logic [0:0] {
    WAIT_VS = 1'b0,
    ACCUM   = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [X_W-1:0]   x_cnt;
  logic [Y_W-1:0]   y_cnt;
  logic [X_W-1:0]   x_min_acc;
  logic [X_W-1:0]   x_max_acc;
  logic [Y_W-1:0]   y_min_acc;
  logic [Y_W-1:0]   y_max_acc;
  logic [CNT_W-1:0] pix_cnt;

  logic frame_end;
  logic line_end;
  logic white_pix;
  logic acc_clr;
  logic acc_upd;
  logic report;
  logic found;
  logic in_x;
  logic in_y;
  logic border;

  // o_v_sync / o_vga_blank double as the registered copies used for edge detection.
  assign frame_end = o_v_sync & ~i_v_sync;
  assign line_end  = o_vga_blank & ~i_vga_blank;
  assign white_pix = i_vga_blank & i_bin[7];
  assign found     = (pix_cnt >= CNT_W'(MIN_PIX));

  // Column counter: counts active pixels, cleared by any blanking cycle, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      x_cnt <= '0;
    end else if (!i_vga_blank) begin
      x_cnt <= '0;
    end else if (x_cnt != '1) begin
      x_cnt <= x_cnt + 1'b1;
    end
  end

  // Row counter: advances at the end of each active line, held at zero during vsync, saturating.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      y_cnt <= '0;
    end else if (!i_v_sync) begin
      y_cnt <= '0;
    end else if (line_end && (y_cnt != '1)) begin
      y_cnt <= y_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= WAIT_VS;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: the partial frame after reset is skipped; afterwards every frame end reports.
  // A white pixel on the frame-end cycle itself is dropped because the clear takes priority.
  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_upd   = 1'b0;
    report    = 1'b0;
    case (state)
      WAIT_VS: begin
        if (frame_end) begin
          state_nxt = ACCUM;
          acc_clr   = 1'b1;
        end
      end
      ACCUM: begin
        if (frame_end) begin
          report  = 1'b1;
          acc_clr = 1'b1;
        end else if (white_pix) begin
          acc_upd = 1'b1;
        end
      end
      default: begin
        state_nxt = WAIT_VS;
      end
    endcase
  end

  // Box accumulators: min registers start all-ones so the first white pixel always wins.
  always_ff @(posedge i_clk) begin
    if (i_rst || acc_clr) begin
      x_min_acc <= '1;
      x_max_acc <= '0;
      y_min_acc <= '1;
      y_max_acc <= '0;
      pix_cnt   <= '0;
    end else if (acc_upd) begin
      if (x_cnt < x_min_acc) x_min_acc <= x_cnt;
      if (x_cnt > x_max_acc) x_max_acc <= x_cnt;
      if (y_cnt < y_min_acc) y_min_acc <= y_cnt;
      if (y_cnt > y_max_acc) y_max_acc <= y_cnt;
      if (pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
    end
  end

  // Result registers: latched once per frame; a frame below threshold reports an all-zero box.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_box_valid <= 1'b0;
      o_box_found <= 1'b0;
      o_x_min     <= '0;
      o_x_max     <= '0;
      o_y_min     <= '0;
      o_y_max     <= '0;
    end else begin
      o_box_valid <= report;
      if (report) begin
        o_box_found <= found;
        o_x_min     <= found ? x_min_acc : '0;
        o_x_max     <= found ? x_max_acc : '0;
        o_y_min     <= found ? y_min_acc : '0;
        o_y_max     <= found ? y_max_acc : '0;
      end
    end
  end

  // Border test of the current pixel against the previously reported box.
  always_comb begin
    in_x   = (x_cnt >= o_x_min) && (x_cnt <= o_x_max);
    in_y   = (y_cnt >= o_y_min) && (y_cnt <= o_y_max);
    border = o_box_found && i_vga_blank &&
             ((in_x && ((y_cnt == o_y_min) || (y_cnt == o_y_max))) ||
              (in_y && ((x_cnt == o_x_min) || (x_cnt == o_x_max))));
  end

  // Video output stage: timing delayed one cycle, colour is overlay, grey passthrough or black.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_h_sync    <= 1'b1;
      o_v_sync    <= 1'b1;
      o_vga_blank <= 1'b0;
      o_r         <= 8'h00;
      o_g         <= 8'h00;
      o_b         <= 8'h00;
    end else begin
      o_h_sync    <= i_h_sync;
      o_v_sync    <= i_v_sync;
      o_vga_blank <= i_vga_blank;
      if (!i_vga_blank) begin
        o_r <= 8'h00;
        o_g <= 8'h00;
        o_b <= 8'h00;
      end else if (border) begin
        o_r <= BOX_R;
        o_g <= BOX_G;
        o_b <= BOX_B;
      end else begin
        o_r <= i_bin;
        o_g <= i_bin;
        o_b <= i_bin;
      end
    end
  end

endmodule

// File: tb/tb_bbox_tracker.sv
// Bench for bbox_tracker on an 8x4 active frame; dut uses MIN_PIX=4, dut1 uses MIN_PIX=1.
// Inputs change on the falling edge and outputs are checked on the following falling edge.
// Frame vectors carry hand-computed box results for both instances.
module tb_bbox_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       h_sync, v_sync, vga_blank;
  logic [7:0] bin;

  logic       oh, ov, ob, vld, fnd;
  logic [7:0] r, g, b;
  logic [9:0] xmn, xmx, ymn, ymx;
  logic       oh1, ov1, ob1, vld1, fnd1;
  logic [7:0] r1, g1, b1;
  logic [9:0] xmn1, xmx1, ymn1, ymx1;

  int total = 0;
  int bad   = 0;
  int vld_cnt = 0;

  always #5 clk = ~clk;

  bbox_tracker #(.MIN_PIX(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_h_sync(h_sync), .i_v_sync(v_sync),
    .i_vga_blank(vga_blank), .i_bin(bin),
    .o_h_sync(oh), .o_v_sync(ov), .o_vga_blank(ob),
    .o_r(r), .o_g(g), .o_b(b),
    .o_box_valid(vld), .o_box_found(fnd),
    .o_x_min(xmn), .o_x_max(xmx), .o_y_min(ymn), .o_y_max(ymx)
  );

  bbox_tracker #(.MIN_PIX(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_h_sync(h_sync), .i_v_sync(v_sync),
    .i_vga_blank(vga_blank), .i_bin(bin),
    .o_h_sync(oh1), .o_v_sync(ov1), .o_vga_blank(ob1),
    .o_r(r1), .o_g(g1), .o_b(b1),
    .o_box_valid(vld1), .o_box_found(fnd1),
    .o_x_min(xmn1), .o_x_max(xmx1), .o_y_min(ymn1), .o_y_max(ymx1)
  );

  typedef struct packed {
    logic [31:0] mask;   // bit y*8+x set = white pixel
    logic        f4;
    logic [9:0]  ax0, ax1, ay0, ay1;
    logic        f1;
    logic [9:0]  bx0, bx1, by0, by1;
  } vec_t;

  vec_t vecs[6];
  vec_t pv;   // result reported at the previous frame end (drives the overlay)

  // Valid pulses of the MIN_PIX=4 instance over the whole run.
  always @(negedge clk) if (vld === 1'b1) vld_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] exp_px(input logic f, input logic [9:0] x0, input logic [9:0] x1,
                                         input logic [9:0] y0, input logic [9:0] y1,
                                         input logic [9:0] x, input logic [9:0] y,
                                         input logic [7:0] pix);
    logic on_box;
    on_box = ((x >= x0) && (x <= x1) && ((y == y0) || (y == y1))) ||
             ((y >= y0) && (y <= y1) && ((x == x0) || (x == x1)));
    if (f && on_box) return 24'hFF0000;
    return {pix, pix, pix};
  endfunction

  task automatic drive(input logic h, input logic v, input logic bl, input logic [7:0] p);
    h_sync = h; v_sync = v; vga_blank = bl; bin = p;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic h, input logic v, input logic bl, input logic [7:0] p);
    drive(h, v, bl, p);
    chk("timing", {61'd0, oh, ov, ob}, {61'd0, h, v, bl});
    chk("timing1", {61'd0, oh1, ov1, ob1}, {61'd0, h, v, bl});
    if (!bl) begin
      chk("blank_rgb", {40'd0, r, g, b}, 64'd0);
      chk("blank_rgb1", {40'd0, r1, g1, b1}, 64'd0);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_timing", {61'd0, oh, ov, ob}, {61'd0, 3'b110});
    chk("rst_rgb", {40'd0, r, g, b}, 64'd0);
    chk("rst_box", {22'd0, vld, fnd, xmn, xmx, ymn, ymx}, 64'd0);
    chk("rst_box1", {22'd0, vld1, fnd1, xmn1, xmx1, ymn1, ymx1}, 64'd0);
  endtask

  task automatic hblank();
    step(1, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
  endtask

  task automatic frame(input logic [31:0] mask);
    logic [7:0] p;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 8; x++) begin
        p = mask[y*8+x] ? 8'hFF : 8'h00;
        step(1, 1, 1, p);
        chk("px", {40'd0, r, g, b},
            {40'd0, exp_px(pv.f4, pv.ax0, pv.ax1, pv.ay0, pv.ay1, 10'(x), 10'(y), p)});
        chk("px1", {40'd0, r1, g1, b1},
            {40'd0, exp_px(pv.f1, pv.bx0, pv.bx1, pv.by0, pv.by1, 10'(x), 10'(y), p)});
      end
      hblank();
    end
  endtask

  task automatic vsync(input logic exp_vld, input vec_t e);
    step(1, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    step(1, 0, 0, 8'h00);   // frame end edge
    chk("valid", {63'd0, vld}, {63'd0, exp_vld});
    chk("valid1", {63'd0, vld1}, {63'd0, exp_vld});
    if (exp_vld) begin
      chk("box", {23'd0, fnd, xmn, xmx, ymn, ymx}, {23'd0, e.f4, e.ax0, e.ax1, e.ay0, e.ay1});
      chk("box1", {23'd0, fnd1, xmn1, xmx1, ymn1, ymx1}, {23'd0, e.f1, e.bx0, e.bx1, e.by0, e.by1});
    end
    step(1, 0, 0, 8'h00);
    chk("valid_pulse_len", {62'd0, vld, vld1}, 64'd0);
    step(1, 0, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
  endtask

  initial begin
    // box (2,1)-(5,2): 8 pixels
    vecs[0] = '{mask: 32'h003C3C00, f4: 1'b1, ax0: 10'd2, ax1: 10'd5, ay0: 10'd1, ay1: 10'd2,
                f1: 1'b1, bx0: 10'd2, bx1: 10'd5, by0: 10'd1, by1: 10'd2};
    // 3 pixels (1,0),(4,2),(6,3): below 4, above 1
    vecs[1] = '{mask: 32'h40100002, f4: 1'b0, ax0: 10'd0, ax1: 10'd0, ay0: 10'd0, ay1: 10'd0,
                f1: 1'b1, bx0: 10'd1, bx1: 10'd6, by0: 10'd0, by1: 10'd3};
    // all black
    vecs[2] = '{mask: 32'h00000000, f4: 1'b0, ax0: 10'd0, ax1: 10'd0, ay0: 10'd0, ay1: 10'd0,
                f1: 1'b0, bx0: 10'd0, bx1: 10'd0, by0: 10'd0, by1: 10'd0};
    // single pixel (7,3)
    vecs[3] = '{mask: 32'h80000000, f4: 1'b0, ax0: 10'd0, ax1: 10'd0, ay0: 10'd0, ay1: 10'd0,
                f1: 1'b1, bx0: 10'd7, bx1: 10'd7, by0: 10'd3, by1: 10'd3};
    // exactly 4 pixels at the corners: threshold boundary, full-frame box
    vecs[4] = '{mask: 32'h81000081, f4: 1'b1, ax0: 10'd0, ax1: 10'd7, ay0: 10'd0, ay1: 10'd3,
                f1: 1'b1, bx0: 10'd0, bx1: 10'd7, by0: 10'd0, by1: 10'd3};
    // all black after a found frame
    vecs[5] = '{mask: 32'h00000000, f4: 1'b0, ax0: 10'd0, ax1: 10'd0, ay0: 10'd0, ay1: 10'd0,
                f1: 1'b0, bx0: 10'd0, bx1: 10'd0, by0: 10'd0, by1: 10'd0};
    pv = '0;

    // Reset for 3 cycles with inputs opposite to the reset values.
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 8'hFF);
      chk_reset_state();
    end
    rst = 1'b0;

    step(1, 1, 0, 8'h00);
    step(1, 1, 0, 8'h00);
    frame(32'hFFFFFFFF);          // partial frame before first frame end: never reported
    vsync(1'b0, vecs[0]);

    for (int i = 0; i < 6; i++) begin
      frame(vecs[i].mask);
      vsync(1'b1, vecs[i]);
      pv = vecs[i];
    end

    // Reset in the middle of a line of a white frame.
    step(1, 1, 1, 8'hFF);
    step(1, 1, 1, 8'hFF);
    step(1, 1, 1, 8'hFF);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 8'hFF);
      chk_reset_state();
    end
    rst = 1'b0;
    pv = '0;
    drive(1, 1, 1, 8'hFF);
    drive(1, 1, 1, 8'hFF);
    hblank();
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < 8; x++) step(1, 1, 1, 8'hFF);
      hblank();
    end
    vsync(1'b0, vecs[0]);         // first frame end after reset: no report
    frame(vecs[0].mask);
    vsync(1'b1, vecs[0]);

    chk("valid_count", 64'(vld_cnt), 64'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
